// File: rtl/pkt_buf_writer_if.sv
// Bus bundle between the byte source, the packet RAM write port and the packet reader.
interface pkt_buf_writer_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_data;
  logic              ram_we;
  logic [1:0]        pkt_ready;
  logic [1:0]        pkt_done;
  logic [15:0]       overflow_cnt;
  logic [15:0]       seq;

  // Writer side: consumes bytes and release pulses, drives RAM and status.
  modport master (
    input  in_valid, in_data, pkt_done,
    output ram_addr, ram_data, ram_we, pkt_ready, overflow_cnt, seq
  );

  // Environment side: byte source plus packet reader.
  modport slave (
    output in_valid, in_data, pkt_done,
    input  ram_addr, ram_data, ram_we, pkt_ready, overflow_cnt, seq
  );
endinterface

// File: rtl/pkt_buf_writer.sv
// Packs a byte stream into 16-bit words and writes ping-pong packets into RAM.
//
// state  | meaning
// S_WAIT | no packet open; next byte opens a packet if the current half is free
// S_FILL | packet open in the current half; collecting payload bytes
module pkt_buf_writer #(
  parameter int ADDR_W    = 10,
  parameter int PKT_WORDS = 512
) (
  input  logic          clk,
  input  logic          reset,
  pkt_buf_writer_if.master bus
);

  typedef enum logic {S_WAIT, S_FILL} state_t;

  // Index of the last payload word (word 0 is the header, so payload ends at PKT_WORDS-1).
  localparam logic [ADDR_W-2:0] LAST_IDX = (ADDR_W-1)'(PKT_WORDS - 2);
  localparam logic [ADDR_W-2:0] ONE_IDX  = (ADDR_W-1)'(1);

  state_t            state_q, state_d;
  logic              half_q, half_d;
  logic [ADDR_W-2:0] widx_q, widx_d;
  logic              odd_q, odd_d;
  logic [7:0]        lo_q, lo_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              we_q, we_d;
  logic [1:0]        rdy_q, rdy_d;
  logic [15:0]       ovf_q, ovf_d;
  logic [15:0]       seq_q, seq_d;
  logic [1:0]        commit;
  logic [ADDR_W-2:0] widx_p1;

  // Payload word k lives at offset k+1 inside the half; the offset never spills into the half bit.
  assign widx_p1 = widx_q + ONE_IDX;

  // Next-state and next-output decode for the packet FSM.
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    widx_d  = widx_q;
    odd_d   = odd_q;
    lo_d    = lo_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    ovf_d   = ovf_q;
    seq_d   = seq_q;
    commit  = 2'b00;
    case (state_q)
      S_WAIT: begin
        if (bus.in_valid) begin
          if (rdy_q[half_q]) begin
            if (ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
          end else begin
            // First byte of a packet: use its cycle to write the header word.
            we_d    = 1'b1;
            addr_d  = {half_q, {(ADDR_W-1){1'b0}}};
            data_d  = seq_q;
            lo_d    = bus.in_data;
            odd_d   = 1'b1;
            widx_d  = '0;
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (bus.in_valid) begin
          if (!odd_q) begin
            lo_d  = bus.in_data;
            odd_d = 1'b1;
          end else begin
            we_d   = 1'b1;
            addr_d = {half_q, widx_p1};
            data_d = {bus.in_data, lo_q};
            odd_d  = 1'b0;
            if (widx_q == LAST_IDX) begin
              commit  = half_q ? 2'b10 : 2'b01;
              seq_d   = seq_q + 16'd1;
              half_d  = ~half_q;
              state_d = S_WAIT;
            end else begin
              widx_d = widx_p1;
            end
          end
        end
      end
      default: state_d = S_WAIT;
    endcase
    // A release and a commit of the other half can coincide; both take effect.
    rdy_d = (rdy_q & ~bus.pkt_done) | commit;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_WAIT;
    else       state_q <= state_d;
  end

  // Datapath and registered outputs; reset discards any partial packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      half_q <= 1'b0;
      widx_q <= '0;
      odd_q  <= 1'b0;
      lo_q   <= 8'h00;
      addr_q <= '0;
      data_q <= 16'h0000;
      we_q   <= 1'b0;
      rdy_q  <= 2'b00;
      ovf_q  <= 16'h0000;
      seq_q  <= 16'h0000;
    end else begin
      half_q <= half_d;
      widx_q <= widx_d;
      odd_q  <= odd_d;
      lo_q   <= lo_d;
      addr_q <= addr_d;
      data_q <= data_d;
      we_q   <= we_d;
      rdy_q  <= rdy_d;
      ovf_q  <= ovf_d;
      seq_q  <= seq_d;
    end
  end

  assign bus.ram_addr     = addr_q;
  assign bus.ram_data     = data_q;
  assign bus.ram_we       = we_q;
  assign bus.pkt_ready    = rdy_q;
  assign bus.overflow_cnt = ovf_q;
  assign bus.seq          = seq_q;

endmodule

// File: tb/tb_pkt_buf_writer.sv
// Bench for pkt_buf_writer: packet-level reference model plus directed and random traffic.
module tb_pkt_buf_writer;
  localparam int ADDR_W    = 10;
  localparam int PKT_WORDS = 4;
  localparam int HALF      = 1 << (ADDR_W - 1);
  localparam int PKT_BYTES = 2 * (PKT_WORDS - 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pkt_buf_writer_if #(.ADDR_W(ADDR_W)) bus ();

  pkt_buf_writer #(.ADDR_W(ADDR_W), .PKT_WORDS(PKT_WORDS)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the open packet is a queue of bytes; everything else follows from its length.
  logic [7:0] m_q[$];
  int         m_half = 0;
  logic [1:0] m_rdy = 2'b00;
  int         m_seq = 0;
  int         m_ovf = 0;
  logic       e_we = 1'b0;
  int         e_addr = 0;
  int         e_data = 0;
  logic       e_chk_ad = 1'b1;
  int         wl_a[$];
  int         wl_d[$];

  always @(posedge clk) begin
    logic [1:0] old_rdy;
    logic [1:0] set;
    int n;
    e_we = 1'b0;
    if (reset) begin
      m_q.delete();
      m_half = 0; m_rdy = 2'b00; m_seq = 0; m_ovf = 0;
      e_addr = 0; e_data = 0; e_chk_ad = 1'b1;
    end else begin
      e_chk_ad = 1'b0;
      old_rdy = m_rdy;
      set = 2'b00;
      if (bus.in_valid) begin
        if (m_q.size() == 0 && old_rdy[m_half]) begin
          if (m_ovf != 65535) m_ovf++;
        end else begin
          m_q.push_back(bus.in_data);
          n = m_q.size();
          if (n == 1) begin
            e_we = 1'b1; e_chk_ad = 1'b1;
            e_addr = m_half * HALF;
            e_data = m_seq;
          end else if (n % 2 == 0) begin
            e_we = 1'b1; e_chk_ad = 1'b1;
            e_addr = m_half * HALF + n / 2;
            e_data = {16'h0, m_q[n-1], m_q[n-2]};
            if (n == PKT_BYTES) begin
              set[m_half] = 1'b1;
              m_seq = (m_seq + 1) % 65536;
              m_half = 1 - m_half;
              m_q.delete();
            end
          end
        end
      end
      m_rdy = (old_rdy & ~bus.pkt_done) | set;
    end
    #1;
    if (bus.ram_we) begin
      wl_a.push_back(int'(bus.ram_addr));
      wl_d.push_back(int'(bus.ram_data));
    end
    n_cmp++;
    if (bus.ram_we !== e_we || bus.pkt_ready !== m_rdy || int'(bus.seq) != m_seq ||
        int'(bus.overflow_cnt) != m_ovf ||
        (e_chk_ad && (int'(bus.ram_addr) != e_addr || int'(bus.ram_data) != e_data))) begin
      n_bad++;
      $display("FAIL cycle t=%0t we %0b want %0b addr %0d want %0d data %h want %h rdy %b want %b seq %0d want %0d ovf %0d want %0d",
               $time, bus.ram_we, e_we, bus.ram_addr, e_addr, bus.ram_data, e_data[15:0],
               bus.pkt_ready, m_rdy, bus.seq, m_seq, bus.overflow_cnt, m_ovf);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got %0d (0x%h) want %0d (0x%h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic chk_log(input string nm, input int i, input int a, input int d);
    if (i >= wl_a.size()) chk({nm, "_present"}, wl_a.size(), i + 1);
    else begin
      chk({nm, "_addr"}, wl_a[i], a);
      chk({nm, "_data"}, wl_d[i], d);
    end
  endtask

  task automatic tick(input logic v, input logic [7:0] d, input logic [1:0] dn);
    @(posedge clk); #2;
    bus.in_valid = v; bus.in_data = d; bus.pkt_done = dn;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 8'h00, 2'b00);
  endtask

  task automatic clear_log();
    wl_a.delete(); wl_d.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1; bus.in_valid = 1'b0; bus.pkt_done = 2'b00;
    @(posedge clk); #2;
    chk("rst_we",   int'(bus.ram_we), 0);
    chk("rst_addr", int'(bus.ram_addr), 0);
    chk("rst_data", int'(bus.ram_data), 0);
    chk("rst_rdy",  int'(bus.pkt_ready), 0);
    chk("rst_seq",  int'(bus.seq), 0);
    chk("rst_ovf",  int'(bus.overflow_cnt), 0);
    reset = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.pkt_done = 2'b00;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Idle after reset: no writes, all status zero.
    clear_log();
    idle(21);
    chk("idle_writes", wl_a.size(), 0);
    chk("idle_rdy", int'(bus.pkt_ready), 0);
    chk("idle_seq", int'(bus.seq), 0);

    // First packet, continuous bytes.
    clear_log();
    for (int i = 1; i <= 6; i++) tick(1'b1, 8'(i), 2'b00);
    idle(2);
    chk("p0_nwr", wl_a.size(), 4);
    chk_log("p0_w0", 0, 0, 16'h0000);
    chk_log("p0_w1", 1, 1, 16'h0201);
    chk_log("p0_w2", 2, 2, 16'h0403);
    chk_log("p0_w3", 3, 3, 16'h0605);
    chk("p0_rdy", int'(bus.pkt_ready), 1);
    chk("p0_seq", int'(bus.seq), 1);
    chk("p0_model_rdy", int'(m_rdy), 1);

    // Second packet into half 1 with gaps between bytes.
    clear_log();
    for (int i = 7; i <= 12; i++) begin
      tick(1'b1, 8'(i), 2'b00);
      idle(3);
    end
    chk("p1_nwr", wl_a.size(), 4);
    chk_log("p1_w0", 0, 512, 16'h0001);
    chk_log("p1_w1", 1, 513, 16'h0807);
    chk_log("p1_w2", 2, 514, 16'h0A09);
    chk_log("p1_w3", 3, 515, 16'h0C0B);
    chk("p1_rdy", int'(bus.pkt_ready), 3);
    chk("p1_seq", int'(bus.seq), 2);

    // Both halves full: bytes dropped; then release half 0 and refill immediately.
    clear_log();
    for (int i = 0; i < 10; i++) tick(1'b1, 8'(8'hA0 + i), 2'b00);
    idle(1);
    chk("ovf_nwr", wl_a.size(), 0);
    chk("ovf_cnt", int'(bus.overflow_cnt), 10);
    chk("ovf_model", m_ovf, 10);
    tick(1'b0, 8'h00, 2'b01);
    for (int i = 8'h21; i <= 8'h26; i++) tick(1'b1, 8'(i), 2'b00);
    idle(2);
    chk_log("p2_w0", 0, 0, 16'h0002);
    chk_log("p2_w1", 1, 1, 16'h2221);
    chk_log("p2_w3", 3, 3, 16'h2625);
    chk("p2_rdy", int'(bus.pkt_ready), 3);
    chk("p2_seq", int'(bus.seq), 3);

    // Partial packet then reset: next packet restarts at half 0 with header 0.
    tick(1'b0, 8'h00, 2'b11);
    for (int i = 0; i < 3; i++) tick(1'b1, 8'(8'h50 + i), 2'b00);
    do_reset();
    clear_log();
    for (int i = 8'h61; i <= 8'h66; i++) tick(1'b1, 8'(i), 2'b00);
    idle(2);
    chk_log("p3_w0", 0, 0, 16'h0000);
    chk_log("p3_w1", 1, 1, 16'h6261);
    chk("p3_rdy", int'(bus.pkt_ready), 1);
    chk("p3_seq", int'(bus.seq), 1);

    // Random traffic with random releases, checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [1:0] dn;
      dn = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      tick($urandom_range(0, 3) != 0, 8'($urandom), dn);
    end
    idle(2);

    // Saturation of the drop counter with both halves held.
    do_reset();
    for (int i = 0; i < 2 * PKT_BYTES; i++) tick(1'b1, 8'(i), 2'b00);
    for (int i = 0; i < 70000; i++) tick(1'b1, 8'(i), 2'b00);
    idle(2);
    chk("sat_ovf", int'(bus.overflow_cnt), 16'hFFFF);
    chk("sat_model", m_ovf, 65535);
    chk("sat_rdy", int'(bus.pkt_ready), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
